// File: rtl/exe_mem_stage.sv
// exe_mem_stage: EXE -> MEM pipeline register with a valid/ready handshake.
//
// This stage holds the ALU result, store data and control bits of each
// accepted instruction until the MEM stage takes them. The result and store
// data pass through bit-exact. The architectural status register {Z,C,N,V}
// is written when an S-instruction is accepted, not when it retires, so
// carry_out follows the newest flag-setting instruction even while MEM stalls.
//
// Configuration macro: SKID_BUFFER_EN
//   undefined (default) : 1-entry register, combinational
//                         in_ready = out_ready | !out_valid
//   defined             : 2-entry queue (head + skid), registered
//                         in_ready = !(occupancy == 2)
module exe_mem_stage #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  flush,
  input  logic                  wb_en_in,
  input  logic                  mem_r_en_in,
  input  logic                  mem_w_en_in,
  input  logic                  s_in,
  input  logic [3:0]            dest_in,
  input  logic [WORD_WIDTH-1:0] alu_result_in,
  input  logic [WORD_WIDTH-1:0] st_val_in,
  input  logic [3:0]            sr_in,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  wb_en,
  output logic                  mem_r_en,
  output logic                  mem_w_en,
  output logic [3:0]            dest,
  output logic [WORD_WIDTH-1:0] alu_result,
  output logic [WORD_WIDTH-1:0] st_val,
  output logic [3:0]            status,
  output logic                  carry_out
);

  // One queued instruction as seen by the MEM stage.
  typedef struct packed {
    logic                  wb_en;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic [3:0]            dest;
    logic [WORD_WIDTH-1:0] alu_result;
    logic [WORD_WIDTH-1:0] st_val;
  } entry_t;

  localparam int     ENTRY_W    = $bits(entry_t);
  localparam entry_t ENTRY_ZERO = entry_t'({ENTRY_W{1'b0}});

  // An emptied head keeps its data but must never enable writeback or memory.
  function automatic entry_t drop_ctrl(input entry_t e);
    entry_t r;
    r          = e;
    r.wb_en    = 1'b0;
    r.mem_r_en = 1'b0;
    r.mem_w_en = 1'b0;
    return r;
  endfunction

  entry_t     in_entry_s;
  entry_t     head_r;
  entry_t     head_next_s;
  logic       head_valid_r;
  logic       head_valid_next_s;
  logic [3:0] status_r;
  logic [3:0] status_next_s;
  logic       in_ready_s;
  logic       accept_s;
  logic       retire_s;

  assign in_entry_s.wb_en      = wb_en_in;
  assign in_entry_s.mem_r_en   = mem_r_en_in;
  assign in_entry_s.mem_w_en   = mem_w_en_in;
  assign in_entry_s.dest       = dest_in;
  assign in_entry_s.alu_result = alu_result_in;
  assign in_entry_s.st_val     = st_val_in;

  // Handshake qualifiers: flushed inputs are never accepted.
  always_comb begin
    accept_s = in_valid & in_ready_s & ~flush;
    retire_s = head_valid_r & out_ready;
  end

  // Status follows every accepted flag-setting instruction.
  always_comb begin
    status_next_s = status_r;
    if (accept_s && s_in) begin
      status_next_s = sr_in;
    end else begin
      status_next_s = status_r;
    end
  end

`ifdef SKID_BUFFER_EN

  entry_t     skid_r;
  entry_t     skid_next_s;
  logic [1:0] occ_r;
  logic [1:0] occ_next_s;
  logic       in_ready_r;
  logic       in_ready_next_s;

  assign in_ready_s = in_ready_r;

  // Two-entry queue: head feeds MEM, skid catches the entry behind it.
  always_comb begin
    head_next_s = head_r;
    skid_next_s = skid_r;
    occ_next_s  = occ_r;
    case ({accept_s, retire_s})
      2'b10: begin
        case (occ_r)
          2'd0: begin
            head_next_s = in_entry_s;
            occ_next_s  = 2'd1;
          end
          2'd1: begin
            skid_next_s = in_entry_s;
            occ_next_s  = 2'd2;
          end
          default: begin
            occ_next_s = occ_r;
          end
        endcase
      end
      2'b01: begin
        case (occ_r)
          2'd1: begin
            head_next_s = drop_ctrl(head_r);
            occ_next_s  = 2'd0;
          end
          2'd2: begin
            head_next_s = skid_r;
            occ_next_s  = 2'd1;
          end
          default: begin
            occ_next_s = occ_r;
          end
        endcase
      end
      2'b11: begin
        case (occ_r)
          2'd1: begin
            head_next_s = in_entry_s;
          end
          2'd2: begin
            head_next_s = skid_r;
            skid_next_s = in_entry_s;
          end
          default: begin
            occ_next_s = occ_r;
          end
        endcase
      end
      default: begin
        occ_next_s = occ_r;
      end
    endcase
    head_valid_next_s = (occ_next_s != 2'd0);
    in_ready_next_s   = (occ_next_s != 2'd2);
  end

  // Skid-side state; ready comes from a flop so it never depends on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_r     <= ENTRY_ZERO;
      occ_r      <= 2'd0;
      in_ready_r <= 1'b1;
    end else begin
      skid_r     <= skid_next_s;
      occ_r      <= occ_next_s;
      in_ready_r <= in_ready_next_s;
    end
  end

`else

  assign in_ready_s = out_ready | ~head_valid_r;

  // Single register: a new entry may replace the head in the cycle it retires.
  always_comb begin
    head_next_s       = head_r;
    head_valid_next_s = head_valid_r;
    case ({accept_s, retire_s})
      2'b10, 2'b11: begin
        head_next_s       = in_entry_s;
        head_valid_next_s = 1'b1;
      end
      2'b01: begin
        head_next_s       = drop_ctrl(head_r);
        head_valid_next_s = 1'b0;
      end
      default: begin
        head_valid_next_s = head_valid_r;
      end
    endcase
  end

`endif

  // Head entry and status register; reset overrides any handshake activity.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_r       <= ENTRY_ZERO;
      head_valid_r <= 1'b0;
      status_r     <= 4'b0000;
    end else begin
      head_r       <= head_next_s;
      head_valid_r <= head_valid_next_s;
      status_r     <= status_next_s;
    end
  end

  assign in_ready   = in_ready_s;
  assign out_valid  = head_valid_r;
  assign wb_en      = head_r.wb_en;
  assign mem_r_en   = head_r.mem_r_en;
  assign mem_w_en   = head_r.mem_w_en;
  assign dest       = head_r.dest;
  assign alu_result = head_r.alu_result;
  assign st_val     = head_r.st_val;
  assign status     = status_r;
  assign carry_out  = status_r[2];

endmodule

// File: tb/tb_exe_mem_stage.sv
// Directed bench for exe_mem_stage: a vector table for single-entry flows,
// then hand-written sequences for stall/backpressure, streaming and reset.
module tb_exe_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        wb_en_in;
  logic        mem_r_en_in;
  logic        mem_w_en_in;
  logic        s_in;
  logic [3:0]  dest_in;
  logic [31:0] alu_result_in;
  logic [31:0] st_val_in;
  logic [3:0]  sr_in;
  logic        out_valid;
  logic        out_ready;
  logic        wb_en;
  logic        mem_r_en;
  logic        mem_w_en;
  logic [3:0]  dest;
  logic [31:0] alu_result;
  logic [31:0] st_val;
  logic [3:0]  status;
  logic        carry_out;

  int n_pass  = 0;
  int n_total = 0;

  exe_mem_stage #(.WORD_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
    .s_in(s_in), .dest_in(dest_in), .alu_result_in(alu_result_in),
    .st_val_in(st_val_in), .sr_in(sr_in), .out_valid(out_valid),
    .out_ready(out_ready), .wb_en(wb_en), .mem_r_en(mem_r_en), .mem_w_en(mem_w_en),
    .dest(dest), .alu_result(alu_result), .st_val(st_val), .status(status),
    .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic        fl;
    logic        s;
    logic [3:0]  sr;
    logic        wb;
    logic        mr;
    logic        mw;
    logic [3:0]  dst;
    logic [31:0] alu;
    logic [31:0] st;
    logic        e_valid;
    logic        e_wb;
    logic        e_mr;
    logic        e_mw;
    logic [3:0]  e_dst;
    logic [31:0] e_alu;
    logic [31:0] e_st;
    logic [3:0]  e_status;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic drive(input logic vld, input logic fl, input logic s, input logic [3:0] sr,
                       input logic wb, input logic mr, input logic mw, input logic [3:0] dst,
                       input logic [31:0] alu, input logic [31:0] st);
    in_valid = vld; flush = fl; s_in = s; sr_in = sr;
    wb_en_in = wb; mem_r_en_in = mr; mem_w_en_in = mw;
    dest_in = dst; alu_result_in = alu; st_val_in = st;
  endtask

  function automatic vec_t mk(input logic vld, input logic fl, input logic s, input logic [3:0] sr,
                              input logic wb, input logic mr, input logic mw, input logic [3:0] dst,
                              input logic [31:0] alu, input logic [31:0] st,
                              input logic ev, input logic [3:0] est);
    vec_t v;
    v.vld = vld; v.fl = fl; v.s = s; v.sr = sr; v.wb = wb; v.mr = mr; v.mw = mw;
    v.dst = dst; v.alu = alu; v.st = st;
    v.e_valid = ev; v.e_status = est;
    // an accepted entry appears unchanged on the outputs; an empty stage shows no control
    v.e_wb = ev & wb; v.e_mr = ev & mr; v.e_mw = ev & mw;
    v.e_dst = dst; v.e_alu = alu; v.e_st = st;
    return v;
  endfunction

  logic [2:0] exp_rdy;
  int         n_stalled;

  initial begin
    //            vld  fl   s    sr       wb   mr   mw   dst    alu            st             ev   status
    vecs[0] = mk(1'b1,1'b0,1'b0,4'b0000,1'b1,1'b0,1'b0,4'd3, 32'h0000_0005,32'h0000_0000,1'b1,4'b0000);
    vecs[1] = mk(1'b1,1'b0,1'b1,4'b0100,1'b0,1'b1,1'b0,4'd7, 32'hAAAA_5555,32'h1234_5678,1'b1,4'b0100);
    vecs[2] = mk(1'b1,1'b0,1'b0,4'b1000,1'b0,1'b0,1'b1,4'd15,32'hFFFF_FFFF,32'hDEAD_BEEF,1'b1,4'b0100);
    vecs[3] = mk(1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,4'd0, 32'h0000_0000,32'h0000_0000,1'b0,4'b0100);
    vecs[4] = mk(1'b1,1'b1,1'b1,4'b1111,1'b1,1'b1,1'b1,4'd9, 32'h0BAD_0BAD,32'h0000_0001,1'b0,4'b0100);
    vecs[5] = mk(1'b1,1'b0,1'b1,4'b0000,1'b1,1'b0,1'b0,4'd0, 32'h0000_0000,32'h0000_0000,1'b1,4'b0000);
    vecs[6] = mk(1'b1,1'b0,1'b1,4'b1110,1'b1,1'b0,1'b0,4'd9, 32'h8000_0001,32'h7FFF_FFFE,1'b1,4'b1110);
    vecs[7] = mk(1'b0,1'b0,1'b0,4'b0000,1'b0,1'b0,1'b0,4'd0, 32'h0000_0000,32'h0000_0000,1'b0,4'b1110);

`ifdef SKID_BUFFER_EN
    exp_rdy   = 3'b011;
    n_stalled = 2;
`else
    exp_rdy   = 3'b001;
    n_stalled = 1;
`endif

    // reset
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,1'b0,4'd0,32'd0,32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_status",    {28'd0, status},    32'd0);
    chk("rst_carry",     {31'd0, carry_out}, 32'd0);
    chk("rst_ctrl",      {29'd0, wb_en, mem_r_en, mem_w_en}, 32'd0);
    chk("rst_dest",      {28'd0, dest},      32'd0);
    chk("rst_alu",       alu_result,         32'd0);
    chk("rst_st",        st_val,             32'd0);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);

    // vector table, MEM always ready
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(vecs[i].vld, vecs[i].fl, vecs[i].s, vecs[i].sr, vecs[i].wb, vecs[i].mr,
            vecs[i].mw, vecs[i].dst, vecs[i].alu, vecs[i].st);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_ctrl", i), {29'd0, wb_en, mem_r_en, mem_w_en},
          {29'd0, vecs[i].e_wb, vecs[i].e_mr, vecs[i].e_mw});
      chk($sformatf("v%0d_status", i), {28'd0, status}, {28'd0, vecs[i].e_status});
      chk($sformatf("v%0d_carry", i), {31'd0, carry_out}, {31'd0, vecs[i].e_status[2]});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_dest", i), {28'd0, dest}, {28'd0, vecs[i].e_dst});
        chk($sformatf("v%0d_alu", i), alu_result, vecs[i].e_alu);
        chk($sformatf("v%0d_st", i), st_val, vecs[i].e_st);
      end
    end

    // MEM stalled, three back-to-back inputs 1,2,3
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(1'b1,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0,4'd1,32'(k + 1),32'd0);
      out_ready = 1'b0;
      #1;
      chk($sformatf("stall_in_ready_%0d", k), {31'd0, in_ready}, {31'd0, exp_rdy[k]});
    end
    @(negedge clk);
    drive(1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,1'b0,4'd0,32'd0,32'd0);
    out_ready = 1'b1;
    #1;
    for (int j = 0; j < n_stalled; j++) begin
      chk($sformatf("drain_valid_%0d", j), {31'd0, out_valid}, 32'd1);
      chk($sformatf("drain_alu_%0d", j), alu_result, 32'(j + 1));
      @(posedge clk); #1;
    end
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("drain_wb_off", {31'd0, wb_en}, 32'd0);

    // streaming: retire and accept in the same cycle
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      drive(1'b1,1'b0,1'b0,4'd0,1'b1,1'b0,1'b0,4'd2,32'(16 + k),32'd0);
      out_ready = 1'b1;
      #1;
      chk($sformatf("stream_in_ready_%0d", k), {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1;
      chk($sformatf("stream_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream_alu_%0d", k), alu_result, 32'(16 + k));
    end
    @(negedge clk);
    drive(1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,1'b0,4'd0,32'd0,32'd0);
    @(posedge clk); #1;
    chk("stream_empty", {31'd0, out_valid}, 32'd0);

    // fill while stalled, then reset over in-flight entries
    @(negedge clk);
    drive(1'b1,1'b0,1'b1,4'b1010,1'b1,1'b0,1'b0,4'd4,32'd33,32'd0);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("fill_status", {28'd0, status}, 32'h0000_000A);
    chk("fill_carry", {31'd0, carry_out}, 32'd0);
    @(negedge clk);
    drive(1'b1,1'b0,1'b0,4'b0000,1'b1,1'b0,1'b0,4'd5,32'd34,32'd0);
    @(posedge clk); #1;
    chk("fill_hold_valid", {31'd0, out_valid}, 32'd1);
    chk("fill_hold_alu", alu_result, 32'd33);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1,1'b0,1'b1,4'b1111,1'b1,1'b0,1'b0,4'd6,32'd35,32'd0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst2_status", {28'd0, status}, 32'd0);
    chk("rst2_carry", {31'd0, carry_out}, 32'd0);
    chk("rst2_alu", alu_result, 32'd0);
    chk("rst2_wb", {31'd0, wb_en}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(1'b0,1'b0,1'b0,4'd0,1'b0,1'b0,1'b0,4'd0,32'd0,32'd0);
    out_ready = 1'b0;
    #1;
    chk("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    chk("rst2_no_entry", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
